// File: rtl/max2d_window_scheduler_pkg.sv
// max2d_window_scheduler_pkg: shared widths, window position indices and pipeline flag type
// for the 2x2 max-pool window scheduler.
package max2d_window_scheduler_pkg;

    localparam int BIT_DATA    = 8;
    localparam int MAX2D_KSIZE = 4;
    localparam int MAX2D_KLAT  = 1;

    localparam int MAX2D_TL = 0;
    localparam int MAX2D_TR = 1;
    localparam int MAX2D_BL = 2;
    localparam int MAX2D_BR = 3;

    // Travels alongside each window through the fixed-latency kernel.
    typedef struct packed {
        logic last;
        logic valid;
    } flag_t;

    function automatic int half(input int n);
        return n / 2;
    endfunction

endpackage

// File: rtl/max2d_window_scheduler_if.sv
// max2d_window_scheduler_if: control, pixel stream, packed window and pooled output signals.
interface max2d_window_scheduler_if
    import max2d_window_scheduler_pkg::*;
#(
    parameter int FILTER_IN = 32
);
    localparam int PIX = BIT_DATA * FILTER_IN;
    localparam int WIN = BIT_DATA * MAX2D_KSIZE * FILTER_IN;

    logic           start;
    logic           busy;
    logic           done;
    logic [PIX-1:0] x;
    logic           x_valid;
    logic           x_ready;
    logic [WIN-1:0] win;
    logic           win_valid;
    logic [PIX-1:0] y_layer;
    logic [PIX-1:0] y;
    logic           y_valid;
    logic           y_last;

    modport master (
        input  start, x, x_valid, y_layer,
        output busy, done, x_ready, win, win_valid, y, y_valid, y_last
    );

    modport slave (
        output start, x, x_valid, y_layer,
        input  busy, done, x_ready, win, win_valid, y, y_valid, y_last
    );

endinterface

// File: rtl/max2d_window_scheduler_valid_delay.sv
// max2d_window_scheduler_valid_delay: WIDTH x DEPTH shift register with async reset,
// used to track flags through a fixed-latency datapath.
module max2d_window_scheduler_valid_delay #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] sr [DEPTH];

    always_ff @(posedge clock or posedge reset)
        if (reset)
            for (int i = 0; i < DEPTH; i++) sr[i] <= '0;
        else begin
            sr[0] <= d;
            for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
        end

    assign q = sr[DEPTH-1];

endmodule

// File: rtl/max2d_window_scheduler.sv
// max2d_window_scheduler: buffers one row of a raster pixel stream, forms non-overlapping
// 2x2 windows for layer_max2d and tracks its fixed latency to flag pooled outputs.
module max2d_window_scheduler
    import max2d_window_scheduler_pkg::*;
#(
    parameter int FILTER_IN = 32,
    parameter int IN_W      = 28,
    parameter int IN_H      = 28,
    parameter int KLAT      = MAX2D_KLAT
) (
    input logic                      clock,
    input logic                      reset,
    max2d_window_scheduler_if.master bus
);
    localparam int PIX   = BIT_DATA * FILTER_IN;
    localparam int WIN   = BIT_DATA * MAX2D_KSIZE * FILTER_IN;
    localparam int TOTAL = half(IN_W) * half(IN_H);
    localparam int CW    = $clog2(IN_W);
    localparam int RW    = $clog2(IN_H + 1);
    localparam int OW    = $clog2(TOTAL + 1);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] EVEN_ROW = 2'd1;
    localparam logic [1:0] ODD_ROW  = 2'd2;
    localparam logic [1:0] DRAIN    = 2'd3;

    if (IN_W < 2 || IN_W % 2 != 0 || IN_H < 2 || IN_H % 2 != 0 || KLAT < 1) begin : g_param_check
        $error("max2d_window_scheduler: IN_W and IN_H must be even and >= 2, KLAT must be >= 1");
    end

    logic [1:0]     state;
    logic [CW-1:0]  col;
    logic [RW-1:0]  row;
    logic [OW-1:0]  out_cnt;
    logic [PIX-1:0] row_buf [IN_W];
    logic [PIX-1:0] hold_reg;
    logic [PIX-1:0] top_l, top_r;
    logic [WIN-1:0] win_q;
    flag_t          win_flag, y_flag;
    logic           xfer, col_end, win_load, done;

    assign bus.x_ready = state == EVEN_ROW || state == ODD_ROW;
    assign bus.busy    = state != IDLE;
    assign xfer        = bus.x_valid && bus.x_ready;
    assign col_end     = col == CW'(IN_W - 1);
    assign win_load    = xfer && state == ODD_ROW && col[0];
    assign top_l       = row_buf[col - 1'b1];
    assign top_r       = row_buf[col];

    // Final pooled pixel of the frame; the count keeps a deep kernel from ending early.
    assign done = state == DRAIN && y_flag.valid && out_cnt == OW'(TOTAL - 1);

    assign bus.done      = done;
    assign bus.win       = win_q;
    assign bus.win_valid = win_flag.valid;
    assign bus.y         = bus.y_layer;
    assign bus.y_valid   = y_flag.valid;
    assign bus.y_last    = y_flag.last;

    always_ff @(posedge clock or posedge reset)
        if (reset) begin
            state   <= IDLE;
            col     <= '0;
            row     <= '0;
            out_cnt <= '0;
        end else begin
            case (state)
                IDLE:
                    if (bus.start) begin
                        state <= EVEN_ROW;
                        col   <= '0;
                        row   <= '0;
                    end
                EVEN_ROW:
                    if (xfer) begin
                        col <= col_end ? '0 : col + 1'b1;
                        if (col_end) begin
                            row   <= row + 1'b1;
                            state <= ODD_ROW;
                        end
                    end
                ODD_ROW:
                    if (xfer) begin
                        col <= col_end ? '0 : col + 1'b1;
                        if (col_end) begin
                            row   <= row + 1'b1;
                            state <= row == RW'(IN_H - 1) ? DRAIN : EVEN_ROW;
                        end
                    end
                default:
                    if (done) state <= IDLE;
            endcase
            out_cnt <= done ? '0 : y_flag.valid ? out_cnt + 1'b1 : out_cnt;
        end

    always_ff @(posedge clock or posedge reset)
        if (reset) begin
            win_q    <= '0;
            win_flag <= '0;
        end else begin
            win_flag.valid <= win_load;
            win_flag.last  <= win_load && col_end;
            if (win_load)
                for (int i = 0; i < FILTER_IN; i++) begin
                    win_q[i*MAX2D_KSIZE*BIT_DATA + BIT_DATA*MAX2D_TL +: BIT_DATA] <= top_l[i*BIT_DATA +: BIT_DATA];
                    win_q[i*MAX2D_KSIZE*BIT_DATA + BIT_DATA*MAX2D_TR +: BIT_DATA] <= top_r[i*BIT_DATA +: BIT_DATA];
                    win_q[i*MAX2D_KSIZE*BIT_DATA + BIT_DATA*MAX2D_BL +: BIT_DATA] <= hold_reg[i*BIT_DATA +: BIT_DATA];
                    win_q[i*MAX2D_KSIZE*BIT_DATA + BIT_DATA*MAX2D_BR +: BIT_DATA] <= bus.x[i*BIT_DATA +: BIT_DATA];
                end
        end

    // Row storage is rewritten every frame before use, so it carries no reset.
    always_ff @(posedge clock) begin
        if (xfer && state == EVEN_ROW) row_buf[col] <= bus.x;
        if (xfer && state == ODD_ROW && !col[0]) hold_reg <= bus.x;
    end

    max2d_window_scheduler_valid_delay #(
        .WIDTH($bits(flag_t)),
        .DEPTH(KLAT)
    ) u_valid_delay (
        .clock(clock),
        .reset(reset),
        .d    (win_flag),
        .q    (y_flag)
    );

endmodule
